// File: rtl/xc_sha256_msched_if.sv
// rtl/xc_sha256_msched_if.sv - block input, schedule output and shared sigma port bundle
interface xc_sha256_msched_if;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        w_last;
    logic [31:0] sig_rs1;
    logic [1:0]  sig_ss;
    logic [31:0] sig_result;

    modport slave (
        input  blk_valid, blk_data, w_ready, sig_result,
        output blk_ready, w_valid, w_data, w_idx, w_last, sig_rs1, sig_ss
    );

    modport master (
        output blk_valid, blk_data, w_ready, sig_result,
        input  blk_ready, w_valid, w_data, w_idx, w_last, sig_rs1, sig_ss
    );
endinterface

// File: rtl/xc_sha256_msched.sv
// rtl/xc_sha256_msched.sv - SHA-256 message schedule sequencer over a shared sigma unit
module xc_sha256_msched #(
    parameter int ROUNDS = 64
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  flush,
    output logic                  busy,
    xc_sha256_msched_if.slave     bus
);
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_EMITL,
        S_SIG1,
        S_SIG0,
        S_EMITX
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] out_q, out_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        t_d           = t_q;
        acc_d         = acc_q;
        out_d         = out_q;
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        bus.blk_ready = 1'b0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.sig_ss    = 2'b00;
        bus.sig_rs1   = '0;

        case (state_q)
            S_LOAD: begin
                bus.blk_ready = 1'b1;
                if (bus.blk_valid) begin
                    win_d[cnt_q] = bus.blk_data;
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_EMITL;
                        t_d     = '0;
                    end
                end
            end
            S_EMITL: begin
                bus.w_valid = 1'b1;
                bus.w_data  = win_q[t_q[3:0]];
                if (bus.w_ready) begin
                    t_d = t_q + 6'd1;
                    if (t_q == 6'd15) state_d = S_SIG1;
                end
            end
            // win[14] = W[t-2], win[9] = W[t-7]
            S_SIG1: begin
                bus.sig_ss  = 2'b01;
                bus.sig_rs1 = win_q[14];
                acc_d       = bus.sig_result + win_q[9];
                state_d     = S_SIG0;
            end
            // win[1] = W[t-15], win[0] = W[t-16]
            S_SIG0: begin
                bus.sig_ss  = 2'b00;
                bus.sig_rs1 = win_q[1];
                out_d       = acc_q + bus.sig_result + win_q[0];
                state_d     = S_EMITX;
            end
            S_EMITX: begin
                bus.w_valid = 1'b1;
                bus.w_data  = out_q;
                if (bus.w_ready) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
                    win_d[15] = out_q;
                    t_d       = t_q + 6'd1;
                    if (t_q == LAST_T) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        t_d     = '0;
                    end else begin
                        state_d = S_SIG1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Abort wins over any handshake in the same cycle.
        if (flush) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            t_d     = '0;
        end
    end

    assign bus.w_idx  = t_q;
    assign bus.w_last = bus.w_valid & (t_q == LAST_T);
    assign busy       = (state_q != S_LOAD);
endmodule

// File: tb/tb_xc_sha256_msched.sv
// tb/tb_xc_sha256_msched.sv - bench for xc_sha256_msched (ROUNDS=64 and ROUNDS=20 builds)
module tb_xc_sha256_msched;
    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        blk_valid = 1'b0;
    logic [31:0] blk_data = '0;
    logic        w_ready = 1'b0;
    logic        sel = 1'b0;
    logic        busy1, busy2;

    int checks = 0;
    int failures = 0;

    logic [31:0] cur_blk [16];
    logic [31:0] ref_w [64];
    logic [31:0] got [64];
    logic [31:0] got_abc [64];
    logic [31:0] got_zero [64];

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    xc_sha256_msched_if bi1 ();
    xc_sha256_msched_if bi2 ();

    assign bi1.blk_valid  = blk_valid & ~sel;
    assign bi1.blk_data   = blk_data;
    assign bi1.w_ready    = w_ready & ~sel;
    assign bi1.sig_result = (bi1.sig_ss == 2'b01) ? ssig1(bi1.sig_rs1) : ssig0(bi1.sig_rs1);
    assign bi2.blk_valid  = blk_valid & sel;
    assign bi2.blk_data   = blk_data;
    assign bi2.w_ready    = w_ready & sel;
    assign bi2.sig_result = (bi2.sig_ss == 2'b01) ? ssig1(bi2.sig_rs1) : ssig0(bi2.sig_rs1);

    xc_sha256_msched #(.ROUNDS(64)) dut1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .busy(busy1), .bus(bi1)
    );
    xc_sha256_msched #(.ROUNDS(20)) dut2 (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .busy(busy2), .bus(bi2)
    );

    logic        o_blk_ready, o_w_valid, o_w_last, o_busy;
    logic [31:0] o_w_data, o_sig_rs1;
    logic [5:0]  o_w_idx;
    logic [1:0]  o_sig_ss;

    always_comb begin
        if (sel) begin
            o_blk_ready = bi2.blk_ready; o_w_valid = bi2.w_valid; o_w_last = bi2.w_last;
            o_busy = busy2; o_w_data = bi2.w_data; o_sig_rs1 = bi2.sig_rs1;
            o_w_idx = bi2.w_idx; o_sig_ss = bi2.sig_ss;
        end else begin
            o_blk_ready = bi1.blk_ready; o_w_valid = bi1.w_valid; o_w_last = bi1.w_last;
            o_busy = busy1; o_w_data = bi1.w_data; o_sig_rs1 = bi1.sig_rs1;
            o_w_idx = bi1.w_idx; o_sig_ss = bi1.sig_ss;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int rounds_cur();
        return sel ? 20 : 64;
    endfunction

    task automatic build_ref();
        for (int i = 0; i < 16; i++) ref_w[i] = cur_blk[i];
        for (int t = 16; t < 64; t++)
            ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic load_block(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                blk_valid = 1'b0;
                @(posedge g_clk); #1;
            end
            blk_valid = 1'b1;
            blk_data  = cur_blk[i];
            if (!o_blk_ready) chk($sformatf("blk_ready_word%0d", i), 32'(o_blk_ready), 32'd1);
            @(posedge g_clk); #1;
        end
        blk_valid = 1'b0;
    endtask

    task automatic collect(input int stop_n, input bit rand_bp, output int nhs, output int n_sig1);
        int          cyc;
        int          n;
        bit          held_v;
        bit          prev_s1;
        logic [31:0] hd;
        logic [5:0]  hi;
        cyc = 0; n = 0; held_v = 0; prev_s1 = 0; n_sig1 = 0; hd = '0; hi = '0;
        while (n < stop_n && cyc < 3000) begin
            w_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (held_v) begin
                chk("stall_w_data", o_w_data, hd);
                chk("stall_w_idx", 32'(o_w_idx), 32'(hi));
            end
            chk("w_last", 32'(o_w_last), 32'(o_w_valid && (n == rounds_cur() - 1)));
            if (o_sig_ss == 2'b01) begin
                chk($sformatf("sig1_rs1_t%0d", n), o_sig_rs1, ref_w[n-2]);
                prev_s1 = 1; n_sig1++;
            end else begin
                if (prev_s1) chk($sformatf("sig0_rs1_t%0d", n), {o_sig_ss, o_sig_rs1[29:0]},
                                 {2'b00, ref_w[n-15][29:0]});
                prev_s1 = 0;
            end
            if (o_w_valid && w_ready) begin
                chk("w_idx", 32'(o_w_idx), 32'(n));
                got[n] = o_w_data;
                n++;
            end
            held_v = o_w_valid && !w_ready;
            hd = o_w_data; hi = o_w_idx;
            @(posedge g_clk); #1;
            cyc++;
        end
        w_ready = 1'b0;
        if (n < stop_n) chk("collect_timeout", 32'(n), 32'(stop_n));
        nhs = n;
    endtask

    task automatic run_block(input bit rand_bp);
        int nhs, ns1, r;
        r = rounds_cur();
        build_ref();
        load_block(rand_bp);
        chk("first_word_valid", 32'(o_w_valid), 32'd1);
        chk("first_word_idx", 32'(o_w_idx), 32'd0);
        collect(r, rand_bp, nhs, ns1);
        chk("busy_after_last", 32'(o_busy), 32'd0);
        chk("ready_after_last", 32'(o_blk_ready), 32'd1);
        chk("handshakes", 32'(nhs), 32'(r));
        chk("sig1_cycles", 32'(ns1), 32'(r - 16));
        for (int i = 0; i < nhs; i++) chk($sformatf("W%0d", i), got[i], ref_w[i]);
    endtask

    task automatic wait_valid_idx(input int idx);
        int c;
        c = 0;
        while (!o_w_valid && c < 20) begin @(posedge g_clk); #1; c++; end
        chk("wait_valid", 32'(o_w_valid), 32'd1);
        chk("stop_idx", 32'(o_w_idx), 32'(idx));
    endtask

    typedef struct {
        int          blk;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int   nhs, ns1;
        tbl[0] = '{0, 0,  32'h61626380};
        tbl[1] = '{0, 15, 32'h00000018};
        tbl[2] = '{0, 16, 32'h61626380};
        tbl[3] = '{0, 17, 32'h000F0000};
        tbl[4] = '{1, 0,  32'h00000000};
        tbl[5] = '{1, 40, 32'h00000000};
        tbl[6] = '{1, 63, 32'h00000000};

        repeat (3) @(posedge g_clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_w_valid", 32'(o_w_valid), 32'd0);
        chk("rst_sig", {30'd0, o_sig_ss}, 32'd0);
        chk("rst_sig_rs1", o_sig_rs1, 32'd0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        chk("rst_blk_ready", 32'(o_blk_ready), 32'd1);
        chk("rst_w_idx", 32'(o_w_idx), 32'd0);

        // "abc" block, consumer always ready
        for (int i = 0; i < 16; i++) cur_blk[i] = '0;
        cur_blk[0] = 32'h61626380; cur_blk[15] = 32'h00000018;
        run_block(1'b0);
        for (int i = 0; i < 64; i++) got_abc[i] = got[i];

        // all-zero block
        for (int i = 0; i < 16; i++) cur_blk[i] = '0;
        run_block(1'b0);
        for (int i = 0; i < 64; i++) got_zero[i] = got[i];

        for (int k = 0; k < 7; k++)
            chk($sformatf("tbl%0d_W%0d", k, tbl[k].idx),
                (tbl[k].blk == 0) ? got_abc[tbl[k].idx] : got_zero[tbl[k].idx], tbl[k].exp);

        // random block with backpressure
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        run_block(1'b1);

        // flush during EMITX at t=30
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        build_ref();
        load_block(1'b0);
        collect(30, 1'b1, nhs, ns1);
        wait_valid_idx(30);
        flush = 1'b1; w_ready = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0; w_ready = 1'b0;
        chk("flush_w_valid", 32'(o_w_valid), 32'd0);
        chk("flush_blk_ready", 32'(o_blk_ready), 32'd1);
        chk("flush_busy", 32'(o_busy), 32'd0);
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        run_block(1'b0);

        // async reset at t=20, away from any clock edge
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        build_ref();
        load_block(1'b0);
        collect(20, 1'b0, nhs, ns1);
        wait_valid_idx(20);
        #2 g_resetn = 1'b0;
        #1;
        chk("arst_w_valid", 32'(o_w_valid), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_w_idx", 32'(o_w_idx), 32'd0);
        chk("arst_sig", {30'd0, o_sig_ss}, 32'd0);
        chk("arst_sig_rs1", o_sig_rs1, 32'd0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        run_block(1'b1);

        // ROUNDS=20 build, two blocks back to back
        sel = 1'b1;
        for (int i = 0; i < 16; i++) cur_blk[i] = '0;
        cur_blk[0] = 32'h61626380; cur_blk[15] = 32'h00000018;
        run_block(1'b0);
        for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
        run_block(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xc_sha256_msched.md
Name: xc_sha256_msched

Overview:
- Sequences the SHA-256 message schedule expansion.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready input, then streams W[0]..W[ROUNDS-1] over a valid/ready output.
- Computes W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] by time-multiplexing one shared, external, combinational sigma unit, selected by a 2-bit ss code.
- Sits between the block buffer and the compression-round logic of the crypto coprocessor.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 17..64.

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to LOAD.
- blk_valid  in  1  input word valid.
- blk_ready  out  1  block can accept an input word.
- blk_data  in  32  input message word, W[0] first.
- w_valid  out  1  output schedule word valid.
- w_ready  in  1  consumer accepts the output word.
- w_data  out  32  schedule word W[w_idx].
- w_idx  out  6  index t of the word on w_data.
- w_last  out  1  high with w_valid when t == ROUNDS-1.
- busy  out  1  high in every state except LOAD.
- sig_rs1  out  32  operand driven to the shared sigma unit.
- sig_ss  out  2  sigma select: 00 = s0, 01 = s1 (10 and 11 never driven).
- sig_result  in  32  sigma unit result, combinational, same cycle.

Behaviour:
- Reset (async, g_resetn=0):
  - State = LOAD; t = 0; load count = 0.
  - 16x32 window, accumulator and output register cleared to 0.
  - w_valid = 0, busy = 0, blk_ready = 1 after reset release, sig_ss = 00, sig_rs1 = 0.
- Window: win[0..15]. For t ≥ 16 it holds W[t-16..t-1], with win[0] = W[t-16].
- LOAD:
  - blk_ready = 1.
  - Each blk_valid & blk_ready handshake writes win[cnt] = blk_data, then cnt++.
  - After the 16th handshake: go to EMITL, t = 0, blk_ready = 0.
- EMITL:
  - w_valid = 1, w_data = win[t], w_idx = t.
  - On w_ready: t++.
  - If t was 15, go to SIG1.
  - If ROUNDS ≤ 16 were legal it would stop here; it is not.
- SIG1 (1 cycle):
  - sig_ss = 01, sig_rs1 = win[14].
  - acc ← sig_result + win[9].
  - Go to SIG0.
- SIG0 (1 cycle):
  - sig_ss = 00, sig_rs1 = win[1].
  - out ← acc + sig_result + win[0], all additions mod 2^32.
  - Go to EMITX.
- EMITX:
  - w_valid = 1, w_data = out, w_idx = t.
  - On w_ready: shift the window down (win[i] ← win[i+1], win[15] ← out), then t++.
  - If t was ROUNDS-1, go to LOAD with cnt = 0. Otherwise go to SIG1.
- Output stability: w_data, w_idx and w_last are held stable while w_valid=1 and w_ready=0.
- Latency:
  - Per derived word: 2 cycles of sigma plus 1 output cycle.
  - A fully ready consumer sees W[16+k] every 3 cycles.
  - The first output word appears on the cycle after the 16th load handshake.
- Sigma port when idle: outside SIG1/SIG0, sig_ss = 00 and sig_rs1 = 0. The sigma unit is free for other users then; sharing arbitration lies outside this block.
- flush:
  - When sampled high in any state: next state LOAD, cnt = 0, t = 0, w_valid = 0.
  - The window contents are don't-care.
  - flush overrides a coincident handshake; that word is not consumed or counted.
- Wrap-around at end of block: a new block may be accepted in the cycle after the last output handshake. No words from the previous block leak into the new one, because the window is fully rewritten.
- w_last = w_valid & (t == ROUNDS-1).

Test Plan:
- Load the "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) with a consumer that is always ready -> W16=0x61626380 and W17=0x000F0000. 64 words emitted, w_last only on w_idx=63, and the results match the software model.
- All-zero block -> W[0..63] = 0. Exactly 64 output handshakes. busy drops in the cycle after the 64th handshake.
- Random block with random w_ready backpressure -> w_data/w_idx held while stalled, the sequence matches the model, and sig_ss follows 01,00 per derived word.
- flush asserted during EMITX at t=30 -> w_valid=0 next cycle, blk_ready=1. A new block then produces correct W[0..63] from the new data.
- g_resetn pulsed low mid-stream (t=20) -> outputs take their reset values immediately (async). After release the block accepts 16 fresh words.
- ROUNDS=20 build -> exactly 20 words, w_last at w_idx=19, back-to-back second block correct.
